// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked, pipelined add/subtract unit.
package adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Per-stage status that travels with the partial result.
    typedef struct packed {
        logic carry;
        logic zero;
    } stage_flags_t;

    function automatic int chunk_width(input int width, input int stages);
        return (stages < 1) ? width : width / stages;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operation/result handshake bundle between a caller (master) and the adder (slave).
interface pipelined_adder_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] op1_i;
    logic [WIDTH-1:0] op2_i;
    logic             sub_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;
    logic             overflow_o;
    logic             zero_o;
    logic [TAG_W-1:0] tag_o;

    modport slave (
        input  valid_i, op1_i, op2_i, sub_i, tag_i, ready_i,
        output ready_o, valid_o, sum_o, carry_o, overflow_o, zero_o, tag_o
    );

    modport master (
        output valid_i, op1_i, op2_i, sub_i, tag_i, ready_i,
        input  ready_o, valid_o, sum_o, carry_o, overflow_o, zero_o, tag_o
    );
endinterface

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice with carry-in, carry-out and slice-zero.
module adder_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             c_o,
    output logic             zero_o
);
    logic [CHUNK:0] total;

    assign total  = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
    assign sum_o  = total[CHUNK-1:0];
    assign c_o    = total[CHUNK];
    assign zero_o = (total[CHUNK-1:0] == '0);
endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract unit that resolves one CHUNK-wide slice per stage, carrying the
// operands, partial result, carry, running zero and tag down a stallable pipeline.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input logic              clk_i,
    input logic              rst_ni,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int LAST  = (STAGES >= 1) ? STAGES - 1 : 0;
    localparam bit PARAM_OK = (STAGES >= 1) && (STAGES <= WIDTH) && (TAG_W >= 1) &&
                              ((WIDTH % ((STAGES >= 1) ? STAGES : 1)) == 0);

    if (!PARAM_OK) begin : g_param_err
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH, TAG_W >= 1");
    end

    logic             advance;
    logic             valid_q  [STAGES];
    logic             valid_d  [STAGES];
    logic [WIDTH-1:0] a_q      [STAGES];
    logic [WIDTH-1:0] a_d      [STAGES];
    logic [WIDTH-1:0] b_q      [STAGES];
    logic [WIDTH-1:0] b_d      [STAGES];
    logic [WIDTH-1:0] res_q    [STAGES];
    logic [WIDTH-1:0] res_d    [STAGES];
    logic [WIDTH-1:0] res_in   [STAGES];
    stage_flags_t     flg_q    [STAGES];
    stage_flags_t     flg_d    [STAGES];
    logic [TAG_W-1:0] tag_q    [STAGES];
    logic [TAG_W-1:0] tag_d    [STAGES];
    logic             carry_in [STAGES];
    logic             zero_in  [STAGES];
    logic [CHUNK-1:0] chunk_sum  [STAGES];
    logic             chunk_cout [STAGES];
    logic             chunk_zero [STAGES];

    // Whole pipe moves together; bubbles are kept so latency stays fixed.
    assign advance     = !valid_q[LAST] || bus.ready_i;
    assign bus.ready_o = advance;

    always_comb begin : stage_inputs
        valid_d[0]  = bus.valid_i;
        a_d[0]      = bus.op1_i;
        b_d[0]      = (bus.sub_i == SUB) ? ~bus.op2_i : bus.op2_i;
        tag_d[0]    = bus.tag_i;
        carry_in[0] = (bus.sub_i == SUB);
        zero_in[0]  = 1'b1;
        res_in[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k]  = valid_q[k-1];
            a_d[k]      = a_q[k-1];
            b_d[k]      = b_q[k-1];
            tag_d[k]    = tag_q[k-1];
            carry_in[k] = flg_q[k-1].carry;
            zero_in[k]  = flg_q[k-1].zero;
            res_in[k]   = res_q[k-1];
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_chunk
        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a_i    (a_d[gi][gi*CHUNK +: CHUNK]),
            .b_i    (b_d[gi][gi*CHUNK +: CHUNK]),
            .c_i    (carry_in[gi]),
            .sum_o  (chunk_sum[gi]),
            .c_o    (chunk_cout[gi]),
            .zero_o (chunk_zero[gi])
        );
    end

    always_comb begin : chunk_merge
        for (int k = 0; k < STAGES; k++) begin
            res_d[k]                     = res_in[k];
            res_d[k][k*CHUNK +: CHUNK]   = chunk_sum[k];
            flg_d[k].carry               = chunk_cout[k];
            flg_d[k].zero                = zero_in[k] & chunk_zero[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                res_q[k]   <= '0;
                flg_q[k]   <= '0;
                tag_q[k]   <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                res_q[k]   <= res_d[k];
                flg_q[k]   <= flg_d[k];
                tag_q[k]   <= tag_d[k];
            end
        end
    end

    // Overflow uses the already-inverted second operand, so one rule covers add and sub.
    assign bus.valid_o    = valid_q[LAST];
    assign bus.sum_o      = res_q[LAST];
    assign bus.carry_o    = flg_q[LAST].carry;
    assign bus.zero_o     = flg_q[LAST].zero;
    assign bus.tag_o      = tag_q[LAST];
    assign bus.overflow_o = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                            (res_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed checks on a 32/2 adder plus random sweeps of 32/1, 64/4 and 8/8 against a reference model.
module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    typedef struct {
        logic [127:0] res;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total_cnt;
    int   bad_cnt;
    vec_t vecs [6];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [127:0] pack_res(input logic [63:0] s, input logic c, input logic o,
                                              input logic z, input logic [7:0] t);
        return {53'd0, t, z, o, c, s};
    endfunction

    pipelined_adder_if #(.WIDTH(32), .TAG_W(TAG_W)) mif ();

    pipelined_adder #(
        .WIDTH  (32),
        .STAGES (2),
        .TAG_W  (TAG_W)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (mif)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int W = (gi == 0) ? 32 : (gi == 1) ? 64 : 8;
        localparam int S = (gi == 0) ? 1  : (gi == 1) ? 4  : 8;

        logic done_f;
        exp_t q[$];

        pipelined_adder_if #(.WIDTH(W), .TAG_W(TAG_W)) sif ();

        pipelined_adder #(
            .WIDTH  (W),
            .STAGES (S),
            .TAG_W  (TAG_W)
        ) u_dut (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .bus    (sif)
        );

        initial begin : run
            logic [W-1:0] aw, bw, sw;
            logic [W:0]   full;
            logic [63:0]  r64, s64;
            logic [7:0]   t8;
            logic         sb, cw, ow, zw;
            exp_t         e;
            int           sent, guard;

            done_f      = 1'b0;
            sif.valid_i = 1'b0;
            sif.ready_i = 1'b1;
            sif.op1_i   = '0;
            sif.op2_i   = '0;
            sif.sub_i   = ADD;
            sif.tag_i   = '0;
            sent        = 0;
            guard       = 0;
            wait (rst_n === 1'b1);
            while (guard < 1000 + 4 * S + 20 && (sent < 1000 || q.size() > 0)) begin
                @(negedge clk);
                guard++;
                if (sif.valid_o) begin
                    if (q.size() == 0) begin
                        check_val("sw_extra", 128'(1), 128'(0));
                    end else begin
                        e   = q.pop_front();
                        s64 = '0;
                        s64[W-1:0] = sif.sum_o;
                        t8  = '0;
                        t8[TAG_W-1:0] = sif.tag_o;
                        check_val("sw_res", pack_res(s64, sif.carry_o, sif.overflow_o, sif.zero_o, t8), e.res);
                        check_val("sw_lat", 128'(cyc), 128'(e.cyc));
                    end
                end
                if (sent < 1000) begin
                    r64 = {$urandom(), $urandom()};
                    case ($urandom_range(0, 7))
                        0:       aw = '1;
                        1:       aw = '0;
                        2:       begin aw = '0; aw[W-1] = 1'b1; end
                        default: aw = r64[W-1:0];
                    endcase
                    r64 = {$urandom(), $urandom()};
                    case ($urandom_range(0, 7))
                        0:       bw = '1;
                        1:       bw = '0;
                        2:       begin bw = '0; bw[W-1] = 1'b1; end
                        default: bw = r64[W-1:0];
                    endcase
                    sb = $urandom_range(0, 1) == 1;
                    if (sb) begin
                        full = {1'b0, aw} - {1'b0, bw};
                        sw   = full[W-1:0];
                        cw   = (aw >= bw);
                        ow   = (aw[W-1] != bw[W-1]) && (sw[W-1] != aw[W-1]);
                    end else begin
                        full = {1'b0, aw} + {1'b0, bw};
                        sw   = full[W-1:0];
                        cw   = full[W];
                        ow   = (aw[W-1] == bw[W-1]) && (sw[W-1] != aw[W-1]);
                    end
                    zw  = (sw == '0);
                    s64 = '0;
                    s64[W-1:0] = sw;
                    t8  = '0;
                    t8[TAG_W-1:0] = sent[TAG_W-1:0];
                    e.res = pack_res(s64, cw, ow, zw, t8);
                    e.cyc = cyc + S;
                    q.push_back(e);
                    sif.valid_i = 1'b1;
                    sif.op1_i   = aw;
                    sif.op2_i   = bw;
                    sif.sub_i   = sb;
                    sif.tag_i   = sent[TAG_W-1:0];
                    sent++;
                end else begin
                    sif.valid_i = 1'b0;
                end
            end
            check_val("sw_drain", 128'(q.size()), 128'(0));
            done_f = 1'b1;
        end
    end

    task automatic run_vec(input vec_t v, input logic [TAG_W-1:0] t);
        int t0;
        int n;
        @(negedge clk);
        mif.valid_i = 1'b1;
        mif.op1_i   = v.a;
        mif.op2_i   = v.b;
        mif.sub_i   = v.sub;
        mif.tag_i   = t;
        t0 = cyc;
        n  = 0;
        do begin
            @(negedge clk);
            mif.valid_i = 1'b0;
            n++;
        end while (!mif.valid_o && n < 10);
        check_val("vec_valid", 128'(mif.valid_o), 128'(1));
        check_val("vec_lat",   128'(cyc - t0), 128'(2));
        check_val("vec_sum",   128'(mif.sum_o), 128'(v.s));
        check_val("vec_carry", 128'(mif.carry_o), 128'(v.c));
        check_val("vec_ovf",   128'(mif.overflow_o), 128'(v.o));
        check_val("vec_zero",  128'(mif.zero_o), 128'(v.z));
        check_val("vec_tag",   128'(mif.tag_o), 128'(t));
        $display("vec %0d: %h %s %h -> sum=%h c=%0b o=%0b z=%0b", t, v.a, v.sub ? "-" : "+", v.b,
                 mif.sum_o, mif.carry_o, mif.overflow_o, mif.zero_o);
    endtask

    initial begin : main
        int          i, got_n, guard;
        logic        will_acc, held;
        logic [31:0] hold_sum;
        logic [3:0]  hold_tag;

        total_cnt = 0;
        bad_cnt   = 0;
        vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};

        // Reset with a pending op and downstream not ready.
        rst_n       = 1'b0;
        mif.valid_i = 1'b1;
        mif.op1_i   = 32'h12345678;
        mif.op2_i   = 32'h11111111;
        mif.sub_i   = ADD;
        mif.tag_i   = 4'hA;
        mif.ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_valid", 128'(mif.valid_o), 128'(0));
        check_val("rst_sum",   128'(mif.sum_o), 128'(0));
        check_val("rst_carry", 128'(mif.carry_o), 128'(0));
        check_val("rst_ovf",   128'(mif.overflow_o), 128'(0));
        check_val("rst_zero",  128'(mif.zero_o), 128'(0));
        check_val("rst_tag",   128'(mif.tag_o), 128'(0));
        check_val("rst_ready", 128'(mif.ready_o), 128'(1));
        $display("reset: valid_o=%0b sum=%h ready_o=%0b", mif.valid_o, mif.sum_o, mif.ready_o);
        mif.valid_i = 1'b0;
        mif.ready_i = 1'b1;
        rst_n       = 1'b1;

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], 4'(k + 1));
        end

        // Stream six ops while downstream stalls for four cycles mid-stream.
        i        = 0;
        got_n    = 0;
        will_acc = 1'b0;
        held     = 1'b0;
        hold_sum = '0;
        hold_tag = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (will_acc) i++;
            if (held) begin
                check_val("bp_hold_v",   128'(mif.valid_o), 128'(1));
                check_val("bp_hold_sum", 128'(mif.sum_o), 128'(hold_sum));
                check_val("bp_hold_tag", 128'(mif.tag_o), 128'(hold_tag));
            end
            mif.ready_i = !(c >= 4 && c < 8);
            #1;
            held = 1'b0;
            if (mif.valid_o && !mif.ready_i) begin
                check_val("bp_ready_o", 128'(mif.ready_o), 128'(0));
                held     = 1'b1;
                hold_sum = mif.sum_o;
                hold_tag = mif.tag_o;
            end
            if (mif.valid_o && mif.ready_i) begin
                check_val("bp_tag", 128'(mif.tag_o), 128'(got_n));
                check_val("bp_sum", 128'(mif.sum_o), 128'(32'h100 + 32'(got_n)));
                $display("bp: retire tag=%0d sum=%h", mif.tag_o, mif.sum_o);
                got_n++;
            end
            mif.valid_i = (i < 6);
            mif.op1_i   = 32'h100;
            mif.op2_i   = 32'(i);
            mif.sub_i   = ADD;
            mif.tag_i   = i[3:0];
            #1;
            will_acc = mif.valid_i && mif.ready_o;
        end
        check_val("bp_count", 128'(got_n), 128'(6));
        check_val("bp_drain", 128'(mif.valid_o), 128'(0));

        guard = 0;
        while (!(g_sweep[0].done_f && g_sweep[1].done_f && g_sweep[2].done_f) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check_val("sweep_done", 128'(g_sweep[0].done_f && g_sweep[1].done_f && g_sweep[2].done_f), 128'(1));

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit; successor to the single-cycle 32-bit combinational adder.
- Splits a WIDTH-bit operation into STAGES equal chunks, adding one chunk per cycle and registering the carry between stages, so wide adds close timing.
- Provides a valid/ready handshake, add/sub mode, unsigned carry/signed overflow/zero flags and a pass-through tag.
- Used by the execute stage and address-generation paths that tolerate multi-cycle latency.

Parameters:
- WIDTH, 32: operand/result width in bits; must be a multiple of STAGES.
- STAGES, 2: pipeline depth, equal to the number of chunks; legal range 1..WIDTH; CHUNK = WIDTH/STAGES.
- TAG_W, 4: width of the caller tag carried alongside each operation; must be >= 1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  input operation valid.
- ready_o  output  1  unit can accept an operation this cycle.
- op1_i  input  WIDTH  first operand.
- op2_i  input  WIDTH  second operand.
- sub_i  input  1  0 = op1+op2; 1 = op1-op2.
- tag_i  input  TAG_W  caller tag, returned unchanged.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.
- sum_o  output  WIDTH  result, modulo 2^WIDTH.
- carry_o  output  1  carry out of the MSB; for sub, 1 = no borrow (op1 >= op2 unsigned).
- overflow_o  output  1  signed two's-complement overflow.
- zero_o  output  1  sum_o == 0.
- tag_o  output  TAG_W  tag of the result.

Behaviour:
- Reset (rst_ni low, asynchronous): all stage valid bits are 0, and all data/flag/tag registers are 0. As a result, valid_o=0, sum_o=0, carry_o=0, overflow_o=0, zero_o=0, tag_o=0 and ready_o=1. Reset asserted mid-operation discards all in-flight operations; nothing is replayed.
- Subtraction: op2 is bit-inverted and the carry-in to chunk 0 is 1. For add, the carry-in is 0.
- Stage k (0..STAGES-1) adds chunk k of op1 and op2' plus the carry registered by stage k-1 (stage 0 uses the carry-in). It registers:
  - the chunk-k result;
  - the carry out;
  - a running zero flag (AND of per-chunk zero);
  - the operand slices for higher chunks, skewed forward;
  - the tag;
  - the signs needed for overflow.
- Latency: an operation accepted in cycle t (valid_i && ready_o) presents valid_o=1 in cycle t+STAGES, if no stall occurs. With STAGES=1 the latency is 1 cycle, i.e. a registered adder.
- Throughput: one operation per cycle when ready_i=1.
- Stall rule: advance = !valid_o || ready_i, and ready_o = advance.
  - When advance=0, every stage register holds its value. Bubbles are not collapsed.
  - valid_o, sum_o, flags and tag_o are held stable while valid_o=1 and ready_i=0.
  - ready_o depends combinationally on ready_i and valid_o only, never on valid_i.
- Result flags:
  - carry_o is the final-stage carry.
  - overflow_o = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the inverted op2 for sub.
  - zero_o is the AND of all chunk-zero bits.
- Outputs when valid_o=0: values are don't-care and do not need to be cleared.
- Wrap-around: the result is modulo 2^WIDTH; no saturation.
- Simultaneous events:
  - Accept and retire in the same cycle is legal; the pipeline shifts.
  - valid_i=1 while ready_o=0: the input is not captured, and the caller must hold it.
- Elaboration: an illegal parameter combination (WIDTH % STAGES != 0, STAGES < 1) triggers an elaboration-time $error.

Decomposition:
- adder_pkg holds:
  - the stage_data_t struct template fields (chunk result, carry, zero, tag);
  - localparam helpers: chunk width function, op-mode constants ADD=1'b0 and SUB=1'b1.
- One sub-module, adder_chunk: a combinational CHUNK-bit add with carry-in, producing sum, carry-out and chunk-zero. It is instantiated STAGES times via generate.
- Pipeline registers and handshake live in pipelined_adder.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles, with valid_i=1 during reset -> valid_o=0, all outputs 0, ready_o=1. Release reset -> first accepted op emerges exactly STAGES cycles after acceptance.
- Basic add and carry (WIDTH=32, STAGES=2): 0x0000FFFF + 0x00000001 -> sum 0x00010000, carry 0, overflow 0, zero 0, valid_o at t+2. The inter-stage carry is exercised.
- Add wrap and zero: 0xFFFFFFFF + 0x00000001 -> sum 0x00000000, carry 1, zero 1, overflow 0.
- Subtract and overflow:
  - 0x80000000 - 0x00000001 (sub_i=1) -> 0x7FFFFFFF, overflow 1, carry 1.
  - 0x00000003 - 0x00000005 -> 0xFFFFFFFE, carry 0, overflow 0.
- Back-pressure: stream 6 ops with tags 0..5, drop ready_i for 4 cycles mid-stream -> no loss or duplication, tags return in order 0..5, outputs held stable during the stall, and ready_o=0 while valid_o=1 and ready_i=0.
- Parameter sweep: (WIDTH,STAGES) = (32,1), (64,4) and (8,8), each with 1000 random ops against a reference model -> exact sum and flags, latency = STAGES.
